// File: rtl/lcm_pkg.sv
// Shared types and defaults for the LCM calculator.
package lcm_pkg;

  localparam int unsigned LCM_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lcm_calc.sv
// LCM from operands and an upstream HCF: shift-add multiply a*b, then
// restoring divide by hcf, sharing one iteration counter.
module lcm_calc
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH = LCM_WIDTH
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     hcf,
  output logic [2*WIDTH-1:0]   lcm,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW + 1);
  localparam int unsigned RW = WIDTH + 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hcf_q, hcf_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [PW-1:0]      quot_q, quot_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [PW-1:0]      lcm_d;
  logic               busy_d, done_d, err_d;
  logic [RW-1:0]      rem_sh, rem_diff;
  logic               take;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hcf_q    <= '0;
      prod_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      lcm      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hcf_q    <= hcf_d;
      prod_q   <= prod_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      lcm      <= lcm_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hcf_d    = hcf_q;
    prod_d   = prod_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    lcm_d    = lcm;
    err_d    = err;
    done_d   = 1'b0;
    rem_sh   = {rem_q[WIDTH-1:0], prod_q[PW-1]};
    rem_diff = rem_sh - {1'b0, hcf_q};
    take     = (rem_sh >= {1'b0, hcf_q});

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(a);
          mplier_d = b;
          hcf_d    = hcf;
          prod_d   = '0;
          quot_d   = '0;
          rem_d    = '0;
          cnt_d    = '0;
          if (hcf != '0) begin
            state_d = MUL;
          end else begin
            state_d = DONE;
            lcm_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        // One restoring step; the product register doubles as the dividend shifter
        rem_d  = take ? rem_diff : rem_sh;
        prod_d = prod_q << 1;
        quot_d = {quot_q[PW-2:0], take};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(PW - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
          lcm_d   = quot_d;
          err_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == MUL) || (state_d == DIV);
  end

endmodule

// File: tb/tb_lcm_calc.sv
// Directed plus randomized checks of lcm_calc against an arithmetic reference.
module tb_lcm_calc;

  localparam int unsigned W   = 4;
  localparam int unsigned LAT = 3 * W;
  localparam int unsigned TMO = 60;

  logic           clk = 1'b0;
  logic           clear, start;
  logic [W-1:0]   a, b, hcf;
  logic [2*W-1:0] lcm;
  logic           busy, done, err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int start_cyc;
  bit saw_done;

  lcm_calc #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .start(start), .a(a), .b(b), .hcf(hcf),
    .lcm(lcm), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_lcm(int x, int y, int h);
    return (h == 0) ? 0 : (x * y) / h;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a request for exactly one sampling edge
  task automatic start_op(input int x, input int y, input int h);
    @(negedge clk);
    a = W'(x); b = W'(y); hcf = W'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_lcm, input int exp_err,
                           input int exp_lat);
    while (!done && (cyc - start_cyc) < TMO) @(negedge clk);
    chk({tag, "_seen"}, int'(done), 1);
    chk({tag, "_lat"}, cyc - start_cyc, exp_lat);
    chk({tag, "_lcm"}, int'(lcm), exp_lcm);
    chk({tag, "_err"}, int'(err), exp_err);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(done), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic full_op(input string tag, input int x, input int y, input int h);
    start_op(x, y, h);
    if (h != 0) chk({tag, "_busy"}, int'(busy), 1);
    wait_done(tag, ref_lcm(x, y, h), (h == 0) ? 1 : 0, (h == 0) ? 0 : LAT);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; a = '0; b = '0; hcf = '0;
    repeat (2) @(negedge clk);
    chk("rst_lcm", int'(lcm), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    clear = 1'b0;

    full_op("d8_12_4", 8, 12, 4);
    full_op("d15_14_1", 15, 14, 1);
    full_op("d15_10_5", 15, 10, 5);
    full_op("d0_7_7", 0, 7, 7);
    full_op("d5_3_0", 5, 3, 0);
    full_op("d7_0_3", 7, 0, 3);
    full_op("d15_15_15", 15, 15, 15);
    full_op("dinc_9_7_4", 9, 7, 4);

    // Clear during DIV aborts with no done pulse
    start_op(8, 12, 4);
    repeat (7) @(negedge clk);
    chk("clr_busy_before", int'(busy), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_lcm", int'(lcm), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_err", int'(err), 0);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("clr_no_done", int'(saw_done), 0);
    full_op("clr_next_6_4_2", 6, 4, 2);

    // Start immediately after clear deasserts
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    full_op("post_clr_3_5_1", 3, 5, 1);

    // Second start while busy is ignored
    start_op(8, 12, 4);
    repeat (3) @(negedge clk);
    a = 4'd15; b = 4'd10; hcf = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_start", 24, 0, LAT);
    repeat (LAT + 4) @(negedge clk);
    chk("ign_no_queue", int'(busy), 0);

    // Inputs changed during MUL, then lcm holds while idle
    start_op(8, 12, 4);
    @(negedge clk);
    a = 4'd3; b = 4'd5;
    wait_done("mid_change", 24, 0, LAT);
    repeat (20) @(negedge clk);
    chk("hold_lcm", int'(lcm), 24);
    chk("hold_err", int'(err), 0);

    // Randomized operands, including mid-operation input noise
    for (int i = 0; i < 40; i++) begin
      int x, y, h;
      x = int'($urandom_range(0, 15));
      y = int'($urandom_range(0, 15));
      h = int'($urandom_range(0, 15));
      start_op(x, y, h);
      a = W'($urandom); b = W'($urandom); hcf = W'($urandom);
      wait_done($sformatf("rnd%0d_%0d_%0d_%0d", i, x, y, h), ref_lcm(x, y, h),
                (h == 0) ? 1 : 0, (h == 0) ? 0 : LAT);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
